seq_alu_driver: RTL and testbench

//  Multi-cycle ALU front end that produces the accumulator's load interface (alout/idac).

---
 rtl/seq_alu_driver.sv | 154 +++++++++++++++
 tb/tb_seq_alu_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_driver.sv
// Multi-cycle ALU front end feeding the accumulator load interface (alout/idac).
// One opcode per accepted start; MUL is a WIDTH-step shift-add, everything else is single-step.
module seq_alu_driver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] acout,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] alout,
  output logic             idac,
  output logic             busy,
  output logic             carry,
  output logic             zero
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [PW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] alout_q, alout_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             idac_q, idac_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] a_lo;
  logic [PW-1:0]    prod_step;
  logic [WIDTH:0]   res_ext;
  logic             finish;

  // Result datapath: res_ext = {flag, WIDTH-bit result}
  always_comb begin
    a_lo      = a_q[WIDTH-1:0];
    prod_step = prod_q + (b_q[0] ? a_q : '0);
    res_ext   = '0;
    case (op_q)
      OP_ADD:  res_ext = {1'b0, a_lo} + {1'b0, b_q};
      OP_SUB:  res_ext = {1'b0, a_lo} - {1'b0, b_q};
      OP_AND:  res_ext = {1'b0, a_lo & b_q};
      OP_OR:   res_ext = {1'b0, a_lo | b_q};
      OP_XOR:  res_ext = {1'b0, a_lo ^ b_q};
      OP_SHL:  res_ext = {a_lo, 1'b0};
      OP_SHR:  res_ext = {a_lo[0], 1'b0, a_lo[WIDTH-1:1]};
      OP_MUL:  res_ext = {|prod_step[PW-1:WIDTH], prod_step[WIDTH-1:0]};
      default: res_ext = '0;
    endcase
  end

  // Next-state and output-register logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    alout_d = alout_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    idac_d  = 1'b0;
    busy_d  = busy_q;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = opcode;
          a_d     = PW'(acout);
          b_d     = bus_in;
          prod_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (op_q == OP_MUL) begin
          prod_d = prod_step;
          a_d    = a_q << 1;
          b_d    = b_q >> 1;
          cnt_d  = cnt_q + CNT_W'(1);
          finish = (cnt_q == CNT_W'(WIDTH - 1));
        end else begin
          finish = 1'b1;
        end
        if (finish) begin
          alout_d = res_ext[WIDTH-1:0];
          carry_d = res_ext[WIDTH];
          zero_d  = (res_ext[WIDTH-1:0] == '0);
          idac_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      alout_q <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      idac_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      alout_q <= alout_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      idac_q  <= idac_d;
      busy_q  <= busy_d;
    end
  end

  assign alout = alout_q;
  assign idac  = idac_q;
  assign busy  = busy_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_seq_alu_driver.sv
// Bench for seq_alu_driver: vector table, random ops, reset aborts and start-while-busy.
// Expected results travel through a scoreboard queue and are checked when idac fires.
module tb_seq_alu_driver;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
  } exp_t;

  logic       clk, rst, start;
  logic [2:0] opcode;
  logic [7:0] acout, bus_in, alout;
  logic       idac, busy, carry, zero;

  logic [7:0] acc_m;
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         idac_cnt = 0;
  logic       prev_idac = 1'b0;

  seq_alu_driver #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .acout(acout),
    .bus_in(bus_in), .alout(alout), .idac(idac), .busy(busy), .carry(carry), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator model: loads alout at the edge that ends the idac cycle
  always @(posedge clk or posedge rst) begin
    if (rst) acc_m <= '0;
    else if (idac) acc_m <= alout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t        e;
    logic [8:0]  w;
    logic [15:0] p;
    e.c = 1'b0;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; e.res = w[7:0]; e.c = w[8]; end
      3'd1: begin e.res = a - b; e.c = (a < b); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin e.res = a << 1; e.c = a[7]; end
      3'd6: begin e.res = a >> 1; e.c = a[0]; end
      default: begin p = a * b; e.res = p[7:0]; e.c = (p[15:8] != 8'h00); end
    endcase
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  // Scoreboard consumer: every idac pulse must match the oldest pending operation
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_idac = 1'b0;
    end else begin
      if (idac) begin
        idac_cnt++;
        check("idac_single_cycle", 32'(prev_idac), 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL idac_unexpected: got idac=1 with alout=%0h, expected no pulse", alout);
        end else begin
          e = sb.pop_front();
          check("alout", 32'(alout), 32'(e.res));
          check("carry", 32'(carry), 32'(e.c));
          check("zero",  32'(zero),  32'(e.z));
        end
      end
      prev_idac = idac;
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input exp_t e, input int lat_exp);
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1; opcode = op; acout = a; bus_in = b;
    @(posedge clk);
    sb.push_back(e);
    #1;
    start = 1'b0; opcode = 3'($urandom); acout = 8'($urandom); bus_in = 8'($urandom);
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = idac;
    end
    check("latency", 32'(lat), 32'(lat_exp));
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("idac_after_done", 32'(idac), 32'd0);
    check("alout_hold", 32'(alout), 32'(e.res));
    check("acc_loaded", 32'(acc_m), 32'(e.res));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alout"}, 32'(alout), 32'd0);
    check({tag, "_idac"},  32'(idac),  32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_carry"}, 32'(carry), 32'd0);
    check({tag, "_zero"},  32'(zero),  32'd0);
  endtask

  task automatic abort_with_reset(input logic [2:0] op, input int edges_before);
    int c0;
    @(negedge clk);
    start = 1'b1; opcode = op; acout = 8'hF0; bus_in = 8'h20;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (edges_before) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_abort");
    c0 = idac_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_idac_after_abort", 32'(idac_cnt - c0), 32'd0);
    check("acc_after_abort", 32'(acc_m), 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    exp_t e;
    int   c0;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    vecs[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1};
    vecs[1]  = '{3'd1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1};
    vecs[2]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1};
    vecs[3]  = '{3'd5, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1};
    vecs[4]  = '{3'd6, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1};
    vecs[5]  = '{3'd4, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1};
    vecs[6]  = '{3'd7, 8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0, 8};
    vecs[7]  = '{3'd7, 8'h20, 8'h10, 8'h00, 1'b1, 1'b1, 8};
    vecs[8]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1};
    vecs[9]  = '{3'd3, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1};
    vecs[10] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1};
    vecs[11] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 8};

    rst = 1'b1; start = 1'b0; opcode = '0; acout = '0; bus_in = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      e.res = vecs[i].res; e.c = vecs[i].c; e.z = vecs[i].z;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, e, vecs[i].lat);
    end

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      run_op(rop, ra, rb, model(rop, ra, rb), (rop == 3'd7) ? 8 : 1);
    end

    abort_with_reset(3'd0, 0);
    run_op(3'd0, 8'hF0, 8'h20, model(3'd0, 8'hF0, 8'h20), 1);
    abort_with_reset(3'd7, 3);

    // start re-pulsed mid-MUL with different operands must be ignored
    @(negedge clk);
    start = 1'b1; opcode = 3'd7; acout = 8'h0C; bus_in = 8'h0B;
    @(posedge clk);
    e.res = 8'h84; e.c = 1'b0; e.z = 1'b0;
    sb.push_back(e);
    #1 start = 1'b0;
    c0 = idac_cnt;
    repeat (2) @(negedge clk);
    start = 1'b1; opcode = 3'd0; acout = 8'h55; bus_in = 8'h66;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("busy_ignore_idac_count", 32'(idac_cnt - c0), 32'd1);
    check("busy_ignore_acc", 32'(acc_m), 32'h84);
    check("busy_ignore_idle", 32'(busy), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
